// File: rtl/delaybuffer_prog_pkg.sv
// Shared types and helpers for the programmable delay line.
package delaybuffer_prog_pkg;

  // Which register drives data_o: the registered bypass/zero word or the RAM read port.
  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_RAM = 1'b1
  } src_e;

  function automatic int ptr_w(input int unsigned max_delay);
    return $clog2(max_delay);
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned delay, input int unsigned max);
    return (delay > max) ? max : delay;
  endfunction

  // (a - b) mod m for a < m and b <= m; depth need not be a power of two.
  function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
    return (a >= b) ? (a - b) : (a + m - b);
  endfunction

endpackage

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port synchronous RAM, one write and one registered read port.
// On an address collision the read returns the contents from before the write.
module ram_1r1w_sync #(
  parameter int width_p = 8,
  parameter int depth_p = 16
) (
  input  logic                       clk_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(depth_p)-1:0] wr_addr_i,
  input  logic [width_p-1:0]         wr_data_i,
  input  logic                       rd_en_i,
  input  logic [$clog2(depth_p)-1:0] rd_addr_i,
  output logic [width_p-1:0]         rd_data_o
);

  logic [width_p-1:0] mem [depth_p];
  logic [width_p-1:0] rd_data_reg;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_reg <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_reg;

endmodule

// File: rtl/delaybuffer_prog.sv
// Runtime-programmable transaction delay line with ready/valid on both sides.
// Optional synchronous flush input when DELAYBUFFER_PROG_FLUSH_EN is defined.
module delaybuffer_prog
  import delaybuffer_prog_pkg::*;
#(
  parameter int width_p     = 8,
  parameter int max_delay_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_ni,
`ifdef DELAYBUFFER_PROG_FLUSH_EN
  input  logic                               flush_i,
`endif
  input  logic [$clog2(max_delay_p+1)-1:0]   delay_i,
  input  logic [width_p-1:0]                 data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic                               valid_o,
  output logic [width_p-1:0]                 data_o,
  input  logic                               ready_i,
  output logic [$clog2(max_delay_p+1)-1:0]   fill_o
);

  localparam int PTR_W = ptr_w(max_delay_p);
  localparam int DLY_W = $clog2(max_delay_p + 1);

  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [DLY_W-1:0]   fill_reg, fill_next;
  logic               valid_reg, valid_next;
  src_e               src_reg, src_next;
  logic [width_p-1:0] byp_reg, byp_next;

  logic               flush;
  logic               acc;
  logic [DLY_W-1:0]   d_eff;
  logic [PTR_W-1:0]   rd_addr;
  logic               ram_re;
  logic [width_p-1:0] ram_q;

`ifdef DELAYBUFFER_PROG_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign ready_o = ~flush & (~valid_reg | ready_i);
  assign acc     = valid_i & ready_o;
  assign d_eff   = DLY_W'(clamp_delay(32'(delay_i), max_delay_p));
  assign rd_addr = PTR_W'(wrap_sub(32'(wr_ptr_reg), 32'(d_eff), max_delay_p));
  // RAM is only consulted when its word will actually reach data_o.
  assign ram_re  = acc & (d_eff != '0) & (fill_reg >= d_eff);

  ram_1r1w_sync #(
    .width_p(width_p),
    .depth_p(max_delay_p)
  ) u_ram (
    .clk_i    (clk_i),
    .wr_en_i  (acc),
    .wr_addr_i(wr_ptr_reg),
    .wr_data_i(data_i),
    .rd_en_i  (ram_re),
    .rd_addr_i(rd_addr),
    .rd_data_o(ram_q)
  );

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    fill_next   = fill_reg;
    valid_next  = valid_reg;
    src_next    = src_reg;
    byp_next    = byp_reg;
    if (flush) begin
      wr_ptr_next = '0;
      fill_next   = '0;
      valid_next  = 1'b0;
      src_next    = SRC_REG;
      byp_next    = '0;
    end else if (acc) begin
      wr_ptr_next = (wr_ptr_reg == PTR_W'(max_delay_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (fill_reg != DLY_W'(max_delay_p)) begin
        fill_next = fill_reg + 1'b1;
      end
      valid_next = 1'b1;
      if (d_eff == '0) begin
        src_next = SRC_REG;
        byp_next = data_i;
      end else if (fill_reg < d_eff) begin
        // Not enough history yet: mask whatever the RAM holds.
        src_next = SRC_REG;
        byp_next = '0;
      end else begin
        src_next = SRC_RAM;
      end
    end else if (ready_i & valid_reg) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      valid_reg  <= 1'b0;
      src_reg    <= SRC_REG;
      byp_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      fill_reg   <= fill_next;
      valid_reg  <= valid_next;
      src_reg    <= src_next;
      byp_reg    <= byp_next;
    end
  end

  assign valid_o = valid_reg;
  assign data_o  = (src_reg == SRC_RAM) ? ram_q : byp_reg;
  assign fill_o  = fill_reg;

endmodule

// File: tb/tb_delaybuffer_prog.sv
// Self-checking bench for delaybuffer_prog against a history-queue reference model.
module tb_delaybuffer_prog;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic [4:0] delay_i = '0;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] data_o;
  logic       ready_i = 1'b1;
  logic [4:0] fill_o;
`ifdef DELAYBUFFER_PROG_FLUSH_EN
  logic       flush_i = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  delaybuffer_prog #(.width_p(8), .max_delay_p(16)) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
`ifdef DELAYBUFFER_PROG_FLUSH_EN
    .flush_i (flush_i),
`endif
    .delay_i (delay_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .fill_o  (fill_o)
  );

  // Reference model: every accepted word since reset, plus the expected output register.
  logic [7:0] hist[$];
  logic       m_valid;
  logic [7:0] m_data;
  logic [4:0] m_fill;
  logic       m_ready;
  logic       obs_ready;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic model_clear();
    hist.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_fill  = 5'd0;
  endtask

  // Drives one cycle starting at posedge+1, returns at the next posedge+1.
  task automatic tick(input logic v, input logic [7:0] din, input logic [4:0] dly, input logic rdy);
    logic acc;
    int   d;
    int   n;
    valid_i = v;
    data_i  = din;
    delay_i = dly;
    ready_i = rdy;
    #1;
    m_ready   = !m_valid || rdy;
    obs_ready = ready_o;
    acc       = v && m_ready;
    @(posedge clk_i);
    if (acc) begin
      d = (dly > 5'd16) ? 16 : int'(dly);
      n = hist.size();
      if (d == 0) m_data = din;
      else if (n >= d) m_data = hist[n-d];
      else m_data = 8'h00;
      hist.push_back(din);
      m_valid = 1'b1;
      m_fill  = (hist.size() >= 16) ? 5'd16 : 5'(hist.size());
      $display("txn n=%0d in=%h delay=%0d expect_out=%h", n, din, d, m_data);
    end else if (rdy && m_valid) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    reset_ni = 1'b0;
    model_clear();
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) $display("FAIL reset_out got v=%b d=%h want v=0 d=00", valid_o, data_o);
    else n_pass++;
    n_checks++;
    if (ready_o !== 1'b1 || fill_o !== 5'd0) $display("FAIL reset_rdy_fill got r=%b f=%0d want r=1 f=0", ready_o, fill_o);
    else n_pass++;
  endtask

  task automatic test_fixed_delay();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 8'(i + 1), 5'd4, 1'b1);
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== ((i < 4) ? 8'h00 : 8'(i - 3)))
        $display("FAIL fixed_delay i=%0d got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, (i < 4) ? 8'h00 : 8'(i - 3));
      else n_pass++;
    end
    tick(1'b0, 8'h00, 5'd4, 1'b1);
    n_checks++;
    if (valid_o !== 1'b0 || fill_o !== 5'd16) $display("FAIL fixed_drain got v=%b f=%0d want v=0 f=16", valid_o, fill_o);
    else n_pass++;
  endtask

  task automatic test_bypass();
    do_reset();
    tick(1'b1, 8'hA5, 5'd0, 1'b1);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 8'hA5) $display("FAIL bypass_a5 got v=%b d=%h want v=1 d=a5", valid_o, data_o);
    else n_pass++;
    tick(1'b1, 8'h3C, 5'd0, 1'b1);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h3C) $display("FAIL bypass_3c got v=%b d=%h want v=1 d=3c", valid_o, data_o);
    else n_pass++;
  endtask

  task automatic test_max_delay_wrap();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 8'(i + 1), 5'd16, 1'b1);
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== ((i < 16) ? 8'h00 : 8'(i - 15)))
        $display("FAIL max_wrap i=%0d got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, (i < 16) ? 8'h00 : 8'(i - 15));
      else n_pass++;
    end
    // Requests above the maximum clamp to it.
    tick(1'b1, 8'd41, 5'd31, 1'b1);
    n_checks++;
    if (data_o !== 8'd25) $display("FAIL clamp got d=%h want d=%h", data_o, 8'd25);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    logic [7:0] held;
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 8'($urandom), 5'd2, 1'b1);
    held = data_o;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'($urandom), 5'd2, 1'b0);
      n_checks++;
      if (obs_ready !== 1'b0 || valid_o !== 1'b1 || data_o !== held)
        $display("FAIL backpressure c=%0d got r=%b v=%b d=%h want r=0 v=1 d=%h", i, obs_ready, valid_o, data_o, held);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      tick(i < 6, 8'($urandom), 5'd2, 1'b1);
      n_checks++;
      if (obs_ready !== m_ready || valid_o !== m_valid || (m_valid && data_o !== m_data))
        $display("FAIL bp_resume c=%0d got r=%b v=%b d=%h want r=%b v=%b d=%h", i, obs_ready, valid_o, data_o, m_ready, m_valid, m_data);
      else n_pass++;
    end
  endtask

  task automatic test_delay_change();
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(100 + i), 5'd3, 1'b1);
    n_checks++;
    if (data_o !== 8'd106) $display("FAIL dchg_before got d=%h want d=%h", data_o, 8'd106);
    else n_pass++;
    for (int i = 10; i < 14; i++) begin
      tick(1'b1, 8'(100 + i), 5'd1, 1'b1);
      n_checks++;
      if (obs_ready !== 1'b1 || valid_o !== 1'b1 || data_o !== 8'(99 + i))
        $display("FAIL dchg_after n=%0d got r=%b v=%b d=%h want r=1 v=1 d=%h", i, obs_ready, valid_o, data_o, 8'(99 + i));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [4:0] dly;
    do_reset();
    dly = 5'd5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) dly = 5'($urandom_range(0, 31));
      tick($urandom_range(0, 3) != 0, 8'($urandom), dly, $urandom_range(0, 2) != 0);
      n_checks++;
      if (obs_ready !== m_ready || valid_o !== m_valid || fill_o !== m_fill || (m_valid && data_o !== m_data))
        $display("FAIL random c=%0d got r=%b v=%b d=%h f=%0d want r=%b v=%b d=%h f=%0d",
                 i, obs_ready, valid_o, data_o, fill_o, m_ready, m_valid, m_data, m_fill);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] want [3];
    want[0] = 8'h00;
    want[1] = 8'h00;
    want[2] = 8'h07;
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, 8'($urandom), 5'd5, 1'b1);
    valid_i = 1'b1;
    #3 reset_ni = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || ready_o !== 1'b1 || fill_o !== 5'd0)
      $display("FAIL async_reset got v=%b d=%h r=%b f=%0d want v=0 d=00 r=1 f=0", valid_o, data_o, ready_o, fill_o);
    else n_pass++;
    model_clear();
    @(posedge clk_i);
    #1 reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'(7 + i), 5'd2, 1'b1);
      n_checks++;
      if (valid_o !== 1'b1 || data_o !== want[i])
        $display("FAIL restart i=%0d got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, want[i]);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    test_reset();
    test_fixed_delay();
    test_bypass();
    test_max_delay_wrap();
    test_back_pressure();
    test_delay_change();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
